vector_stroke_engine: RTL and testbench

- Parametrised successor to the single-point line drawer for the vector display path.
- Buffers a queue of stroke commands (draw/jump plus intensity) in an internal FIFO.
- Rasterises each draw with a Bresenham generator and streams per-point frames of X, Y and Z (beam intensity) samples to a multi-channel DAC through a ready/strobe handshake.
- Jumps move the beam blanked and hold for a programmable settle time.

---
 rtl/vector_stroke_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_vector_stroke_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_stroke_engine.sv
// Vector stroke engine: buffers draw/jump commands, rasterises draws with
// Bresenham and streams X/Y/Z frames to a multi-channel DAC.
module vector_stroke_engine #(
  parameter int WIDTH         = 12,
  parameter int Z_WIDTH       = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int SETTLE_FRAMES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pt_valid,
  output logic                          pt_ready,
  input  logic [WIDTH-1:0]              pt_x,
  input  logic [WIDTH-1:0]              pt_y,
  input  logic [Z_WIDTH-1:0]            pt_z,
  input  logic                          pt_jump,
  input  logic                          dac_ready,
  output logic                          dac_strobe,
  output logic [1:0]                    dac_channel,
  output logic [WIDTH-1:0]              dac_value,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = WIDTH + 2;
  localparam int CW = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam int EW = 2 * WIDTH + Z_WIDTH + 1;
  localparam logic [AW:0]          DEPTH_L = (AW + 1)'(FIFO_DEPTH);
  localparam logic signed [SW-1:0] S_ZERO  = '0;

  typedef enum logic [1:0] {IDLE, LOAD, STEP, EMIT} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic [WIDTH-1:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [WIDTH-1:0]       tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [Z_WIDTH-1:0]     z_q, z_d;
  logic                   jump_q, jump_d;
  logic signed [SW-1:0]   dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                   sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [CW-1:0]          settle_q, settle_d;
  logic                   emitted_q, emitted_d;
  logic [1:0]             chan_q, chan_d;

  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [WIDTH-1:0]       head_x, head_y;
  logic [Z_WIDTH-1:0]     head_z;
  logic                   head_jump;
  logic                   push, pop;

  logic signed [SW-1:0]   diff_x, diff_y, e2;
  logic                   at_target, step_x, step_y;

  assign pt_ready = (level_q < DEPTH_L);
  assign push     = pt_valid && pt_ready;
  assign {head_jump, head_z, head_y, head_x} = mem[rd_ptr_q];

  // NOTE: command storage has no reset; validity is tracked by the pointers
  // and level, so clearing the array would only cost routing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {pt_jump, pt_z, pt_y, pt_x};
  end

  assign diff_x    = $signed({2'b00, tgt_x_q}) - $signed({2'b00, pos_x_q});
  assign diff_y    = $signed({2'b00, tgt_y_q}) - $signed({2'b00, pos_y_q});
  assign at_target = (pos_x_q == tgt_x_q) && (pos_y_q == tgt_y_q);
  assign e2        = err_q <<< 1;
  assign step_x    = (e2 >= dy_q);
  assign step_y    = (e2 <= dx_q);

  // NOTE: every *_d gets its hold value first so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | (pt_valid & ~pt_ready);
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    tgt_x_d    = tgt_x_q;
    tgt_y_d    = tgt_y_q;
    z_d        = z_q;
    jump_d     = jump_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    err_d      = err_q;
    sx_neg_d   = sx_neg_q;
    sy_neg_d   = sy_neg_q;
    settle_d   = settle_q;
    emitted_d  = emitted_q;
    chan_d     = chan_q;
    pop        = 1'b0;

    // The whole engine stalls while the DAC is not ready.
    if (dac_ready) begin
      unique case (state_q)
        IDLE: begin
          if (level_q != '0) begin
            pop     = 1'b1;
            tgt_x_d = head_x;
            tgt_y_d = head_y;
            z_d     = head_z;
            jump_d  = head_jump;
            state_d = LOAD;
          end
        end
        LOAD: begin
          dx_d      = (diff_x < 0) ? -diff_x : diff_x;
          dy_d      = (diff_y < 0) ? diff_y : -diff_y;
          sx_neg_d  = (diff_x < 0);
          sy_neg_d  = (diff_y < 0);
          err_d     = ((diff_x < 0) ? -diff_x : diff_x) + ((diff_y < 0) ? diff_y : -diff_y);
          emitted_d = 1'b0;
          chan_d    = 2'd0;
          if (jump_q) begin
            pos_x_d  = tgt_x_q;
            pos_y_d  = tgt_y_q;
            z_d      = '0;
            settle_d = CW'(SETTLE_FRAMES);
            state_d  = EMIT;
          end else begin
            state_d  = STEP;
          end
        end
        STEP: begin
          if (at_target) begin
            // A zero-length draw still owes one frame at the current position.
            state_d = emitted_q ? IDLE : EMIT;
          end else begin
            err_d = err_q + (step_x ? dy_q : S_ZERO) + (step_y ? dx_q : S_ZERO);
            if (step_x) pos_x_d = sx_neg_q ? pos_x_q - WIDTH'(1) : pos_x_q + WIDTH'(1);
            if (step_y) pos_y_d = sy_neg_q ? pos_y_q - WIDTH'(1) : pos_y_q + WIDTH'(1);
            state_d = EMIT;
          end
        end
        EMIT: begin
          if (chan_q == 2'd2) begin
            chan_d    = 2'd0;
            emitted_d = 1'b1;
            if (!jump_q)              state_d  = STEP;
            else if (settle_q != '0)  settle_d = settle_q - CW'(1);
            else                      state_d  = IDLE;
          end else begin
            chan_d = chan_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + (AW + 1)'(1);
    else if (pop && !push) level_d = level_q - (AW + 1)'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      tgt_x_q    <= '0;
      tgt_y_q    <= '0;
      z_q        <= '0;
      jump_q     <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      err_q      <= '0;
      sx_neg_q   <= 1'b0;
      sy_neg_q   <= 1'b0;
      settle_q   <= '0;
      emitted_q  <= 1'b0;
      chan_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      tgt_x_q    <= tgt_x_d;
      tgt_y_q    <= tgt_y_d;
      z_q        <= z_d;
      jump_q     <= jump_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      err_q      <= err_d;
      sx_neg_q   <= sx_neg_d;
      sy_neg_q   <= sy_neg_d;
      settle_q   <= settle_d;
      emitted_q  <= emitted_d;
      chan_q     <= chan_d;
    end
  end

  always_comb begin
    dac_value = '0;
    if (state_q == EMIT) begin
      unique case (chan_q)
        2'd0:    dac_value = pos_x_q;
        2'd1:    dac_value = pos_y_q;
        default: dac_value = WIDTH'(z_q) << (WIDTH - Z_WIDTH);
      endcase
    end
  end

  assign dac_strobe  = (state_q == EMIT) && dac_ready;
  assign dac_channel = (state_q == EMIT) ? chan_q : 2'd0;
  assign busy        = (state_q != IDLE) || (level_q != '0);
  assign fifo_level  = level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_vector_stroke_engine.sv
// Testbench for vector_stroke_engine: a frame-list model predicts every DAC
// sample from the command stream; directed literals pin the model.
module tb_vector_stroke_engine;

  localparam int WIDTH         = 12;
  localparam int Z_WIDTH       = 8;
  localparam int FIFO_DEPTH    = 16;
  localparam int SETTLE_FRAMES = 4;
  localparam int LW            = $clog2(FIFO_DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               pt_valid = 1'b0;
  logic               pt_jump = 1'b0;
  logic               dac_ready = 1'b1;
  logic [WIDTH-1:0]   pt_x = '0;
  logic [WIDTH-1:0]   pt_y = '0;
  logic [Z_WIDTH-1:0] pt_z = '0;
  logic               pt_ready, dac_strobe, busy, overflow;
  logic [1:0]         dac_channel;
  logic [WIDTH-1:0]   dac_value;
  logic [LW-1:0]      fifo_level;

  always #5 clk = ~clk;

  vector_stroke_engine #(
    .WIDTH(WIDTH), .Z_WIDTH(Z_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .SETTLE_FRAMES(SETTLE_FRAMES)
  ) dut (
    .clk(clk), .reset(reset),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_jump(pt_jump),
    .dac_ready(dac_ready), .dac_strobe(dac_strobe),
    .dac_channel(dac_channel), .dac_value(dac_value),
    .busy(busy), .fifo_level(fifo_level), .overflow(overflow)
  );

  typedef struct packed {
    logic [1:0]       chan;
    logic [WIDTH-1:0] val;
  } sample_t;

  sample_t exp_q[$];
  sample_t cur_s;
  int      errors = 0;
  int      checks = 0;
  int      strobe_cnt = 0;
  int      last_x = 0;
  int      last_y = 0;
  int      mdl_x = 0;
  int      mdl_y = 0;
  bit      rand_mode = 1'b0;
  bit      acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic add_frame(input int x, input int y, input int z);
    exp_q.push_back({2'd0, WIDTH'(x)});
    exp_q.push_back({2'd1, WIDTH'(y)});
    exp_q.push_back({2'd2, WIDTH'(z << (WIDTH - Z_WIDTH))});
  endtask

  // Frame list for one command, straight from the stroke rules.
  task automatic model_cmd(input int x1, input int y1, input int z, input bit jump);
    int x, y, dx, dy, sx, sy, err, e2;
    if (jump) begin
      for (int k = 0; k <= SETTLE_FRAMES; k++) add_frame(x1, y1, 0);
    end else begin
      x   = mdl_x;
      y   = mdl_y;
      dx  = (x1 > x) ? x1 - x : x - x1;
      dy  = -((y1 > y) ? y1 - y : y - y1);
      sx  = (x < x1) ? 1 : -1;
      sy  = (y < y1) ? 1 : -1;
      err = dx + dy;
      if (x == x1 && y == y1) add_frame(x, y, z);
      while (!(x == x1 && y == y1)) begin
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
        add_frame(x, y, z);
      end
    end
    mdl_x = x1;
    mdl_y = y1;
  endtask

  // Called and returns at posedge+1; consecutive calls give back-to-back pushes.
  task automatic push_cmd(input int x, input int y, input int z, input bit jump, output bit accepted);
    pt_valid = 1'b1;
    pt_x     = WIDTH'(x);
    pt_y     = WIDTH'(y);
    pt_z     = Z_WIDTH'(z);
    pt_jump  = jump;
    @(negedge clk);
    accepted = pt_ready;
    if (accepted) model_cmd(x, y, z, jump);
    @(posedge clk);
    #1;
    pt_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      #2;
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    check({name, "_drained"}, done, 1);
    if (!done) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      dac_ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: every strobe must match the next predicted sample.
  always @(negedge clk) begin
    if (!reset) begin
      if (!dac_ready) check("strobe_gated", dac_strobe, 0);
      if (dac_strobe) begin
        strobe_cnt++;
        check("strobe_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur_s = exp_q.pop_front();
          check("dac_channel", dac_channel, cur_s.chan);
          check("dac_value", dac_value, cur_s.val);
          if (dac_channel == 2'd0) last_x = dac_value;
          else if (dac_channel == 2'd1) last_y = dac_value;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lx[5];
    int ly[5];
    bit found;
    lx = '{1, 2, 3, 4, 5};
    ly = '{0, 1, 1, 2, 2};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_strobe", dac_strobe, 0);
    check("rst_channel", dac_channel, 0);
    check("rst_value", dac_value, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", pt_ready, 1);
    check("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;

    // Shallow draw (0,0)->(5,2).
    strobe_cnt = 0;
    push_cmd(5, 2, 8'hFF, 1'b0, acc);
    check("busy_after_push", busy, 1);
    check("model_len_5_2", exp_q.size(), 15);
    for (int i = 0; i < 5; i++) begin
      check("model_x_5_2", exp_q[3*i].val, lx[i]);
      check("model_y_5_2", exp_q[3*i+1].val, ly[i]);
      check("model_z_5_2", exp_q[3*i+2].val, 12'hFF0);
    end
    wait_idle(200, "draw_5_2");
    check("strobes_5_2", strobe_cnt, 15);
    check("busy_after_5_2", busy, 0);

    // Jump with settle, then zero-length draw.
    strobe_cnt = 0;
    push_cmd(100, 200, 8'h99, 1'b1, acc);
    wait_idle(200, "jump_100_200");
    check("strobes_jump", strobe_cnt, 15);
    check("jump_last_x", last_x, 100);
    check("jump_last_y", last_y, 200);
    strobe_cnt = 0;
    push_cmd(100, 200, 8'h3C, 1'b0, acc);
    check("model_zero_len_z", exp_q[2].val, 12'h3C0);
    wait_idle(200, "zero_len");
    check("strobes_zero_len", strobe_cnt, 3);

    // Steep negative draw (10,10)->(7,0).
    push_cmd(10, 10, 0, 1'b1, acc);
    wait_idle(200, "jump_10_10");
    strobe_cnt = 0;
    push_cmd(7, 0, 8'h40, 1'b0, acc);
    check("model_len_steep", exp_q.size(), 30);
    check("model_first_y_steep", exp_q[1].val, 9);
    wait_idle(500, "steep");
    check("strobes_steep", strobe_cnt, 30);
    check("steep_last_x", last_x, 7);
    check("steep_last_y", last_y, 0);

    // Full-range diagonal (0,4095)->(4095,0).
    push_cmd(0, 4095, 0, 1'b1, acc);
    wait_idle(200, "jump_0_4095");
    strobe_cnt = 0;
    push_cmd(4095, 0, 8'h01, 1'b0, acc);
    wait_idle(20000, "diag");
    check("strobes_diag", strobe_cnt, 3 * 4095);
    check("diag_last_x", last_x, 4095);
    check("diag_last_y", last_y, 0);

    // Random dac_ready back-pressure over three commands.
    rand_mode = 1'b1;
    push_cmd(4080, 20, 8'h11, 1'b0, acc);
    push_cmd(3, 3, 0, 1'b1, acc);
    push_cmd(0, 9, 8'h80, 1'b0, acc);
    wait_idle(3000, "random_ready");
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    dac_ready = 1'b1;

    // Fill the FIFO with the DAC stalled, then overflow it.
    dac_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_cmd((i * 7) % 50, (i * 5) % 40, i * 9 + 1, (i % 4) == 3, acc);
      check("fill_accept", acc, 1);
    end
    check("full_level", fifo_level, 16);
    check("full_ready", pt_ready, 0);
    check("full_no_strobe", dac_strobe, 0);
    push_cmd(49, 39, 8'hEE, 1'b0, acc);
    check("push17_refused", acc, 0);
    check("overflow_set", overflow, 1);
    check("level_after_refuse", fifo_level, 16);
    dac_ready = 1'b1;
    wait_idle(3000, "fifo_drain");
    check("overflow_sticky", overflow, 1);

    // Reset during the Y sample of a draw frame.
    push_cmd(8, 8, 8'h55, 1'b0, acc);
    push_cmd(1, 1, 0, 1'b1, acc);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #1;
      if (dac_strobe && dac_channel == 2'd1) found = 1'b1;
    end
    check("saw_y_sample", found, 1);
    reset = 1'b1;
    exp_q.delete();
    mdl_x = 0;
    mdl_y = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_strobe", dac_strobe, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    strobe_cnt = 0;
    push_cmd(3, 0, 8'h07, 1'b0, acc);
    check("model_post_rst_x0", exp_q[0].val, 1);
    check("model_post_rst_x2", exp_q[6].val, 3);
    wait_idle(200, "post_reset");
    check("strobes_post_rst", strobe_cnt, 9);
    check("post_rst_last_x", last_x, 3);
    check("post_rst_last_y", last_y, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
